// File: rtl/seven_seg_pkg.sv
// Shared types, constants and the hex-to-segment decode for the 7-segment
// scan controller. Segment vectors are active-low, [6]=CA ... [0]=CG.
package seven_seg_pkg;

  typedef enum logic {S_DEAD, S_LIT} scan_state_t;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  function automatic logic [6:0] hex2seg(input logic [3:0] hex);
    logic [6:0] seg;
    case (hex)
      4'h0: seg = 7'b0000001;
      4'h1: seg = 7'b1001111;
      4'h2: seg = 7'b0010010;
      4'h3: seg = 7'b0000110;
      4'h4: seg = 7'b1001100;
      4'h5: seg = 7'b0100100;
      4'h6: seg = 7'b0100000;
      4'h7: seg = 7'b0001111;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0000100;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b1100000;
      4'hC: seg = 7'b0110001;
      4'hD: seg = 7'b1000010;
      4'hE: seg = 7'b0110000;
      default: seg = 7'b0111000;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seven_seg_decode.sv
// Combinational decode of one selected digit into active-low pin levels.
//   digit : hex nibble of the selected digit
//   dp    : decimal point request, 1 = lit
//   seg   : active-low segments, [6]=CA ... [0]=CG
//   dp_n  : active-low decimal point
module seven_seg_decode
  import seven_seg_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       dp,
  output logic [6:0] seg,
  output logic       dp_n
);

  assign seg  = hex2seg(digit);
  assign dp_n = ~dp;

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with dead-time anti-ghosting,
// 16-level PWM brightness and frame-synchronous (tear-free) input shadowing.
//   clk, rstn     : core clock, asynchronous active-low reset
//   i_digits      : hex nibble per digit, [3:0] = digit 0
//   i_dp          : decimal point per digit, 1 = lit
//   i_digit_en    : per-digit enable, 1 = lit
//   i_brightness  : duty = (i_brightness+1)/16
//   i_blank       : force dark without disturbing the scan timing
//   o_an          : anodes, active-low, at most one low at a time
//   o_seg, o_dp   : active-low segments / decimal point
//   o_frame_tick  : one-clock pulse when the shadow registers reload
module seven_seg_scan_ctrl
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS  = 8,
  parameter int DEAD_CYCLES = 16,
  parameter int SUB_CYCLES  = 96
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [4*NUM_DIGITS-1:0] i_digits,
  input  logic [NUM_DIGITS-1:0]   i_dp,
  input  logic [NUM_DIGITS-1:0]   i_digit_en,
  input  logic [3:0]              i_brightness,
  input  logic                    i_blank,
  output logic [NUM_DIGITS-1:0]   o_an,
  output logic [6:0]              o_seg,
  output logic                    o_dp,
  output logic                    o_frame_tick
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DW    = $clog2(DEAD_CYCLES + 1);
  localparam int SW    = $clog2(SUB_CYCLES + 1);

  scan_state_t             state;
  logic [IDX_W-1:0]        idx;
  logic [DW-1:0]           dead_cnt;
  logic [SW-1:0]           sub_cnt;
  logic [3:0]              pwm_cnt;
  logic                    boot_load;

  logic [4*NUM_DIGITS-1:0] sh_digits;
  logic [NUM_DIGITS-1:0]   sh_dp;
  logic [NUM_DIGITS-1:0]   sh_en;
  logic [3:0]              sh_bright;

  logic [3:0]              cur_digit;
  logic                    cur_dp;
  logic                    cur_en;
  logic [NUM_DIGITS-1:0]   an_onehot;
  logic                    sub_wrap;
  logic                    last_digit;
  logic                    load;
  logic                    lit;
  logic                    seg_on;
  logic [6:0]              dec_seg;
  logic                    dec_dp_n;

  always_comb begin
    cur_digit = '0;
    cur_dp    = 1'b0;
    cur_en    = 1'b0;
    an_onehot = '0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      if (idx == IDX_W'(k)) begin
        cur_digit    = sh_digits[4*k +: 4];
        cur_dp       = sh_dp[k];
        cur_en       = sh_en[k];
        an_onehot[k] = 1'b1;
      end
    end
  end

  assign sub_wrap   = (sub_cnt == SW'(SUB_CYCLES - 1));
  assign last_digit = (idx == IDX_W'(NUM_DIGITS - 1));
  // Reload on the slot-end edge of the last digit, or on the very first
  // dead-time clock after reset so the display never starts from zeros.
  assign load       = ((state == S_DEAD) && boot_load) ||
                      ((state == S_LIT) && sub_wrap && (pwm_cnt == 4'hF) && last_digit);
  assign lit        = (state == S_LIT) && cur_en && !i_blank;
  assign seg_on     = lit && (pwm_cnt <= sh_bright);

  seven_seg_decode u_decode (
    .digit (cur_digit),
    .dp    (cur_dp),
    .seg   (dec_seg),
    .dp_n  (dec_dp_n)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= S_DEAD;
      idx          <= '0;
      dead_cnt     <= '0;
      sub_cnt      <= '0;
      pwm_cnt      <= '0;
      boot_load    <= 1'b1;
      sh_digits    <= '0;
      sh_dp        <= '0;
      sh_en        <= '0;
      sh_bright    <= '0;
      o_an         <= '1;
      o_seg        <= SEG_OFF;
      o_dp         <= 1'b1;
      o_frame_tick <= 1'b0;
    end else begin
      o_an         <= lit ? ~an_onehot : '1;
      o_seg        <= seg_on ? dec_seg : SEG_OFF;
      o_dp         <= seg_on ? dec_dp_n : 1'b1;
      o_frame_tick <= load;

      if (load) begin
        sh_digits <= i_digits;
        sh_dp     <= i_dp;
        sh_en     <= i_digit_en;
        sh_bright <= i_brightness;
        boot_load <= 1'b0;
      end

      case (state)
        S_DEAD: begin
          if (dead_cnt == DW'(DEAD_CYCLES - 1)) begin
            dead_cnt <= '0;
            sub_cnt  <= '0;
            pwm_cnt  <= '0;
            state    <= S_LIT;
          end else begin
            dead_cnt <= dead_cnt + DW'(1);
          end
        end
        S_LIT: begin
          if (sub_wrap) begin
            sub_cnt <= '0;
            pwm_cnt <= pwm_cnt + 4'd1;
            if (pwm_cnt == 4'hF) begin
              state <= S_DEAD;
              idx   <= last_digit ? '0 : idx + IDX_W'(1);
            end
          end else begin
            sub_cnt <= sub_cnt + SW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Self-checking bench for seven_seg_scan_ctrl (8 digits, 2 dead clocks,
// 1 clock per PWM sub-phase: 18-clock slot, 144-clock frame).
module tb_seven_seg_scan_ctrl;

  localparam int ND    = 8;
  localparam int DEAD  = 2;
  localparam int SUB   = 1;
  localparam int SLOT  = DEAD + 16 * SUB;
  localparam int FRAME = ND * SLOT;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [31:0]   i_digits = 32'h76543210;
  logic [7:0]    i_dp = 8'hA5;
  logic [7:0]    i_digit_en = 8'hFF;
  logic [3:0]    i_brightness = 4'd15;
  logic          i_blank = 1'b0;
  logic [7:0]    o_an;
  logic [6:0]    o_seg;
  logic          o_dp;
  logic          o_frame_tick;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  seven_seg_scan_ctrl #(.NUM_DIGITS(ND), .DEAD_CYCLES(DEAD), .SUB_CYCLES(SUB)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .i_digits     (i_digits),
    .i_dp         (i_dp),
    .i_digit_en   (i_digit_en),
    .i_brightness (i_brightness),
    .i_blank      (i_blank),
    .o_an         (o_an),
    .o_seg        (o_seg),
    .o_dp         (o_dp),
    .o_frame_tick (o_frame_tick)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: outputs derived from the cycle count since reset release.
  logic [6:0] seg_tab [16];
  initial begin
    seg_tab = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};
  end

  int          t;
  logic [31:0] m_dig;
  logic [7:0]  m_dp, m_en;
  logic [3:0]  m_br;
  logic [7:0]  exp_an;
  logic [6:0]  exp_seg;
  logic        exp_dp, exp_tick;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      t = 0; m_dig = '0; m_dp = '0; m_en = '0; m_br = '0;
      exp_an = 8'hFF; exp_seg = 7'h7F; exp_dp = 1'b1; exp_tick = 1'b0;
    end else begin
      int pos, dig, pwm;
      logic on, son;
      pos = t % SLOT;
      dig = (t / SLOT) % ND;
      pwm = (pos >= DEAD) ? (pos - DEAD) / SUB : 0;
      on  = (pos >= DEAD) && m_en[dig] && !i_blank;
      son = on && (pwm <= int'(m_br));
      exp_an = 8'hFF;
      if (on) exp_an[dig] = 1'b0;
      exp_seg = son ? seg_tab[m_dig[dig*4 +: 4]] : 7'h7F;
      exp_dp  = son ? ~m_dp[dig] : 1'b1;
      exp_tick = (t == 0) || (t % FRAME == FRAME - 1);
      if (exp_tick) begin
        m_dig = i_digits; m_dp = i_dp; m_en = i_digit_en; m_br = i_brightness;
      end
      t++;
    end
  end

  // Per-cycle comparison, anode exclusivity and tick cadence.
  logic cmp_en = 1'b0;
  int   cyc = 0;
  int   last_tick = -1;
  logic prev_boot = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (cmp_en) begin
      check("an", {24'd0, o_an}, {24'd0, exp_an});
      check("seg", {25'd0, o_seg}, {25'd0, exp_seg});
      check("dp", {31'd0, o_dp}, {31'd0, exp_dp});
      check("tick", {31'd0, o_frame_tick}, {31'd0, exp_tick});
      check("an_onehot", {31'd0, ($countones(~o_an) <= 1)}, 32'd1);
      if (!rstn) begin
        last_tick = -1;
      end else if (o_frame_tick) begin
        // The boot load lands one clock ahead of the regular cadence.
        if (last_tick >= 0 && !prev_boot) check("tick_period", cyc - last_tick, FRAME);
        prev_boot = (last_tick < 0);
        last_tick = cyc;
      end
    end
  end

  task automatic wait_tick(input int maxc);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!o_frame_tick && n < maxc);
    if (!o_frame_tick) check("wait_tick_timeout", 0, 1);
  endtask

  task automatic wait_an(input logic [7:0] v, input int maxc);
    int n = 0;
    while (o_an !== v && n < maxc) begin
      @(negedge clk);
      n++;
    end
    if (o_an !== v) check("wait_an_timeout", {24'd0, o_an}, {24'd0, v});
  endtask

  // Counts over the 144 clocks following a tick: anode-low clocks, lit
  // segment clocks and the union of anodes that went low.
  task automatic measure_frame(output int an_low, output int seg_lit, output logic [7:0] an_any);
    an_low = 0; seg_lit = 0; an_any = '0;
    repeat (FRAME) begin
      @(negedge clk);
      an_low += $countones(~o_an);
      if (o_seg != 7'h7F) seg_lit++;
      an_any |= ~o_an;
    end
  endtask

  initial begin
    int al, sl;
    logic [7:0] any;

    repeat (3) @(negedge clk);
    cmp_en = 1'b1;
    @(negedge clk);
    check("rst_an", {24'd0, o_an}, 32'hFF);
    check("rst_seg", {25'd0, o_seg}, 32'h7F);
    check("rst_dp", {31'd0, o_dp}, 32'd1);

    rstn = 1'b1;
    @(negedge clk);
    check("boot_tick", {31'd0, o_frame_tick}, 32'd1);
    check("boot_an_c1", {24'd0, o_an}, 32'hFF);
    @(negedge clk);
    check("boot_an_c2", {24'd0, o_an}, 32'hFF);
    @(negedge clk);
    check("boot_an_c3", {24'd0, o_an}, 32'hFE);
    check("boot_seg_c3", {25'd0, o_seg}, 32'h01);
    check("boot_dp_c3", {31'd0, o_dp}, 32'd0);

    // Full brightness
    wait_tick(400);
    measure_frame(al, sl, any);
    check("full_an_low", al, 128);
    check("full_seg_lit", sl, 128);

    // Dim: brightness 3 lights the first 4 PWM phases of each slot
    i_brightness = 4'd3;
    wait_tick(400);
    measure_frame(al, sl, any);
    check("dim_an_low", al, 128);
    check("dim_seg_lit", sl, 32);

    // Tear-free update during digit 3
    wait_an(8'hF7, 400);
    i_digits = 32'hFFFF_FFFF;
    wait_an(8'hEF, 400);
    check("tear_digit4", {25'd0, o_seg}, 32'h4C);
    wait_an(8'h7F, 400);
    check("tear_digit7", {25'd0, o_seg}, 32'h0F);
    wait_tick(400);
    wait_an(8'hFE, 400);
    check("tear_new_f", {25'd0, o_seg}, 32'h38);

    // Enables
    i_digit_en = 8'b0000_0101;
    i_brightness = 4'd15;
    wait_tick(400);
    measure_frame(al, sl, any);
    check("en_an_union", {24'd0, any}, 32'h05);
    check("en_an_low", al, 32);

    // Blank: dark one clock later, scan timing untouched
    wait_an(8'hFE, 400);
    i_blank = 1'b1;
    @(negedge clk);
    check("blank_an", {24'd0, o_an}, 32'hFF);
    repeat (300) @(negedge clk);
    check("blank_seg", {25'd0, o_seg}, 32'h7F);
    i_blank = 1'b0;

    // Asynchronous reset in digit 5's slot
    i_digit_en = 8'hFF;
    i_digits = 32'h7654_3210;
    wait_tick(400);
    wait_an(8'hDF, 400);
    #2 rstn = 1'b0;
    #1;
    check("mid_rst_an", {24'd0, o_an}, 32'hFF);
    check("mid_rst_seg", {25'd0, o_seg}, 32'h7F);
    check("mid_rst_dp", {31'd0, o_dp}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check("restart_tick", {31'd0, o_frame_tick}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    check("restart_an", {24'd0, o_an}, 32'hFE);
    check("restart_seg", {25'd0, o_seg}, 32'h01);
    wait_tick(400);
    repeat (20) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
